// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and defaults for the word-serial wide adder.
// Holds the sequencer state encoding and the counter-width helper.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WA_W     = 32;
    localparam int WA_WORDS = 4;

    // A single-word build still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_rca.sv
// N-bit ripple-carry adder shared by the wide-add sequencer.
// Overflow is the carry into the MSB XOR the carry out of it.
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    logic [N:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout     = carry[N];
    assign overflow = carry[N] ^ carry[N-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS*W-bit signed add/subtract run one W-bit word per cycle through a shared adder.
// Optional macro ZERO_FLAG_EN adds the out_zero result flag.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int W     = WA_W,
    parameter int WORDS = WA_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*WORDS-1:0]   in_a,
    input  logic [W*WORDS-1:0]   in_b,
    input  logic                 in_sub,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_ovf
`ifdef ZERO_FLAG_EN
    ,
    output logic                 out_zero
`endif
);

    localparam int TW = W * WORDS;
    localparam int CW = cnt_width(WORDS);

    state_t          state_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic [TW-1:0]   a_reg;
    logic [TW-1:0]   b_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt_reg;
    logic            cout_reg;
    logic            ovf_reg;

    logic [W-1:0]    a_words   [WORDS];
    logic [W-1:0]    b_words   [WORDS];
    logic [W-1:0]    sum_words [WORDS];

    logic [W-1:0]    add_sum;
    logic            add_cout;
    logic            add_ovf;
    logic            last_word;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign a_words[gi]            = a_reg[gi*W +: W];
            assign b_words[gi]            = b_reg[gi*W +: W];
            assign out_sum[gi*W +: W]     = sum_words[gi];

            // Each result word is captured in the RUN cycle that processes it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_words[gi] <= '0;
                end else if (state_reg == RUN && cnt_reg == CW'(gi)) begin
                    sum_words[gi] <= add_sum;
                end
            end
        end
    endgenerate

    ripple_carry_adder #(
        .N (W)
    ) u_adder (
        .a        (a_words[cnt_reg]),
        .b        (b_words[cnt_reg]),
        .cin      (carry_reg),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    assign last_word = (cnt_reg == CW'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so the inversion happens once at accept.
                        a_reg        <= in_a;
                        b_reg        <= in_sub ? ~in_b : in_b;
                        carry_reg    <= in_sub ? 1'b1 : in_cin;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    carry_reg <= add_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_word) begin
                        cout_reg      <= add_cout;
                        ovf_reg       <= add_ovf;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            zero_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            zero_reg <= zero_reg & (add_sum == '0);
        end
    end

    assign out_zero = zero_reg;
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;

endmodule
